// File: rtl/kbd_scan_if.sv
// Receiver-FIFO side of the scancode decoder: byte at the FIFO head, its
// non-empty flag, the overflow indication and the active-low pop strobe.
interface kbd_scan_if;
    logic [7:0] kb_data;
    logic       kb_ready;
    logic       kb_overflow;
    logic       kb_nextdata_n;

    // Driven by the keyboard receiver FIFO
    modport master (
        output kb_data,
        output kb_ready,
        output kb_overflow,
        input  kb_nextdata_n
    );

    // Driven by the scancode decoder
    modport slave (
        input  kb_data,
        input  kb_ready,
        input  kb_overflow,
        output kb_nextdata_n
    );
endinterface

// File: rtl/kbd_scan_decoder.sv
// PS/2 Set-2 scancode decoder: pops bytes from the receiver FIFO, follows the
// E0/F0 prefixes, tracks the single held key with its ASCII value and a press
// counter, and drives six active-low 7-segment digits.
module kbd_scan_decoder #(
    parameter int GAP_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst,
    kbd_scan_if.slave  kb,
    output logic       key_down,
    output logic       key_ext,
    output logic [7:0] scan_code,
    output logic [7:0] ascii,
    output logic [7:0] key_cnt,
    output logic       ovf,
    output logic [7:0] seg0,
    output logic [7:0] seg1,
    output logic [7:0] seg2,
    output logic [7:0] seg3,
    output logic [7:0] seg4,
    output logic [7:0] seg5
);

    typedef enum logic [1:0] {S_IDLE, S_PROC, S_GAP} state_t;

    localparam logic [3:0] GAP_LAST = 4'(GAP_CYCLES - 1);

    state_t     state;
    state_t     state_nxt;
    logic       pop;
    logic [3:0] gap_cnt;
    logic [7:0] rx_byte;
    logic       ext_pend;
    logic       brk_pend;
    logic       same_key;

    // Lowercase ASCII for letter and digit make codes; everything else is 0.
    function automatic logic [7:0] ascii_of(input logic [7:0] code);
        case (code)
            8'h1C: return 8'h61;  8'h32: return 8'h62;  8'h21: return 8'h63;
            8'h23: return 8'h64;  8'h24: return 8'h65;  8'h2B: return 8'h66;
            8'h34: return 8'h67;  8'h33: return 8'h68;  8'h43: return 8'h69;
            8'h3B: return 8'h6A;  8'h42: return 8'h6B;  8'h4B: return 8'h6C;
            8'h3A: return 8'h6D;  8'h31: return 8'h6E;  8'h44: return 8'h6F;
            8'h4D: return 8'h70;  8'h15: return 8'h71;  8'h2D: return 8'h72;
            8'h1B: return 8'h73;  8'h2C: return 8'h74;  8'h3C: return 8'h75;
            8'h2A: return 8'h76;  8'h1D: return 8'h77;  8'h22: return 8'h78;
            8'h35: return 8'h79;  8'h1A: return 8'h7A;
            8'h45: return 8'h30;  8'h16: return 8'h31;  8'h1E: return 8'h32;
            8'h26: return 8'h33;  8'h25: return 8'h34;  8'h2E: return 8'h35;
            8'h36: return 8'h36;  8'h3D: return 8'h37;  8'h3E: return 8'h38;
            8'h46: return 8'h39;
            default: return 8'h00;
        endcase
    endfunction

    // Active-low hex glyph, bit0=a .. bit6=g, decimal point held off.
    function automatic logic [7:0] hex_glyph(input logic [3:0] nib);
        case (nib)
            4'h0: return 8'hC0;  4'h1: return 8'hF9;  4'h2: return 8'hA4;
            4'h3: return 8'hB0;  4'h4: return 8'h99;  4'h5: return 8'h92;
            4'h6: return 8'h82;  4'h7: return 8'hF8;  4'h8: return 8'h80;
            4'h9: return 8'h90;  4'hA: return 8'h88;  4'hB: return 8'h83;
            4'hC: return 8'hC6;  4'hD: return 8'hA1;  4'hE: return 8'h86;
            default: return 8'h8E;
        endcase
    endfunction

    // Next-state logic: pop in IDLE, interpret in PROC, let the FIFO settle in GAP.
    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        case (state)
            S_IDLE: begin
                if (kb.kb_ready) begin
                    pop       = 1'b1;
                    state_nxt = S_PROC;
                end
            end
            S_PROC: state_nxt = S_GAP;
            S_GAP:  if (gap_cnt == GAP_LAST) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Pop strobe is held inactive while reset is asserted, even with data waiting.
    assign kb.kb_nextdata_n = ~(pop & ~rst);

    // State register and gap counter; the counter only runs inside S_GAP.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            gap_cnt <= 4'd0;
        end else begin
            state   <= state_nxt;
            gap_cnt <= (state == S_GAP) ? gap_cnt + 4'd1 : 4'd0;
        end
    end

    // Capture the FIFO head on the pop cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)      rx_byte <= 8'h00;
        else if (pop) rx_byte <= kb.kb_data;
    end

    assign same_key = key_down && (rx_byte == scan_code) && (ext_pend == key_ext);

    // Byte interpretation: prefixes arm flags, other bytes are makes or breaks.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ext_pend  <= 1'b0;
            brk_pend  <= 1'b0;
            key_down  <= 1'b0;
            key_ext   <= 1'b0;
            scan_code <= 8'h00;
            ascii     <= 8'h00;
            key_cnt   <= 8'h00;
        end else if (state == S_PROC) begin
            case (rx_byte)
                8'hE0: ext_pend <= 1'b1;
                8'hF0: brk_pend <= 1'b1;
                default: begin
                    ext_pend <= 1'b0;
                    brk_pend <= 1'b0;
                    if (brk_pend) begin
                        // Breaks for anything but the held key are dropped.
                        if (same_key) key_down <= 1'b0;
                    end else if (!same_key) begin
                        // Typematic repeats of the held key fall through unchanged.
                        scan_code <= rx_byte;
                        key_ext   <= ext_pend;
                        key_down  <= 1'b1;
                        key_cnt   <= key_cnt + 8'd1;
                        ascii     <= ext_pend ? 8'h00 : ascii_of(rx_byte);
                    end
                end
            endcase
        end
    end

    // Sticky overflow flag; decoding carries on regardless.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                 ovf <= 1'b0;
        else if (kb.kb_overflow) ovf <= 1'b1;
    end

    // Code digits blank when no key is held; the counter digits are always lit.
    always_comb begin
        seg0 = key_down ? hex_glyph(scan_code[3:0]) : 8'hFF;
        seg1 = key_down ? hex_glyph(scan_code[7:4]) : 8'hFF;
        seg2 = key_down ? hex_glyph(ascii[3:0])     : 8'hFF;
        seg3 = key_down ? hex_glyph(ascii[7:4])     : 8'hFF;
        seg4 = hex_glyph(key_cnt[3:0]);
        seg5 = hex_glyph(key_cnt[7:4]);
    end

endmodule

// File: tb/tb_kbd_scan_decoder.sv
// Directed bench for kbd_scan_decoder with GAP_CYCLES=1.
module tb_kbd_scan_decoder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       key_down;
    logic       key_ext;
    logic [7:0] scan_code;
    logic [7:0] ascii;
    logic [7:0] key_cnt;
    logic       ovf;
    logic [7:0] seg0, seg1, seg2, seg3, seg4, seg5;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int pop_cyc[$];

    kbd_scan_if kb_bus();

    kbd_scan_decoder #(.GAP_CYCLES(1)) dut (
        .clk       (clk),
        .rst       (rst),
        .kb        (kb_bus),
        .key_down  (key_down),
        .key_ext   (key_ext),
        .scan_code (scan_code),
        .ascii     (ascii),
        .key_cnt   (key_cnt),
        .ovf       (ovf),
        .seg0      (seg0),
        .seg1      (seg1),
        .seg2      (seg2),
        .seg3      (seg3),
        .seg4      (seg4),
        .seg5      (seg5)
    );

    always #5 clk = ~clk;

    // Record the cycle number of every pop strobe seen at a rising edge.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (kb_bus.kb_nextdata_n === 1'b0) pop_cyc.push_back(cyc);
    end

    task automatic do_reset();
        @(negedge clk);
        kb_bus.kb_ready    = 1'b0;
        kb_bus.kb_overflow = 1'b0;
        kb_bus.kb_data     = 8'h00;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    // Offer one byte and return just after the edge that pops it (DUT in S_PROC).
    task automatic pop_byte(input logic [7:0] b);
        int n;
        @(negedge clk);
        kb_bus.kb_data  = b;
        kb_bus.kb_ready = 1'b1;
        #1;
        n = 0;
        while (kb_bus.kb_nextdata_n !== 1'b0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 20) begin
            errors++;
            $display("FAIL pop_timeout: byte %h not popped within %0d cycles", b, n);
        end
        @(posedge clk);
        #1;
        kb_bus.kb_ready = 1'b0;
    endtask

    // Offer one byte and return once its effect is visible on the outputs.
    task automatic send_byte(input logic [7:0] b);
        pop_byte(b);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        kb_bus.kb_data  = 8'h1C;
        kb_bus.kb_ready = 1'b1;
        kb_bus.kb_overflow = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (kb_bus.kb_nextdata_n !== 1'b1) begin errors++; $display("FAIL rst_nextdata: got %b want 1", kb_bus.kb_nextdata_n); end
        checks++; if (key_cnt !== 8'h00) begin errors++; $display("FAIL rst_key_cnt: got %h want 00", key_cnt); end
        checks++; if (key_down !== 1'b0) begin errors++; $display("FAIL rst_key_down: got %b want 0", key_down); end
        checks++; if (scan_code !== 8'h00 || ascii !== 8'h00) begin errors++; $display("FAIL rst_codes: got %h/%h want 00/00", scan_code, ascii); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL rst_ovf: got %b want 0", ovf); end
        checks++; if ({seg3, seg2, seg1, seg0} !== 32'hFFFF_FFFF) begin errors++; $display("FAIL rst_seg0_3: got %h want ffffffff", {seg3, seg2, seg1, seg0}); end
        checks++; if ({seg5, seg4} !== 16'hC0C0) begin errors++; $display("FAIL rst_seg4_5: got %h want c0c0", {seg5, seg4}); end
        kb_bus.kb_ready = 1'b0;
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_make_break();
        do_reset();
        send_byte(8'h1C);
        checks++; if (key_down !== 1'b1) begin errors++; $display("FAIL a_make_down: got %b want 1", key_down); end
        checks++; if (scan_code !== 8'h1C) begin errors++; $display("FAIL a_make_code: got %h want 1c", scan_code); end
        checks++; if (ascii !== 8'h61) begin errors++; $display("FAIL a_make_ascii: got %h want 61", ascii); end
        checks++; if (key_cnt !== 8'h01) begin errors++; $display("FAIL a_make_cnt: got %h want 01", key_cnt); end
        checks++; if ({seg3, seg2, seg1, seg0} !== 32'h82F9_F9C6) begin errors++; $display("FAIL a_make_segs: got %h want 82f9f9c6", {seg3, seg2, seg1, seg0}); end
        send_byte(8'hF0);
        checks++; if (key_down !== 1'b1) begin errors++; $display("FAIL a_prefix_hold: got %b want 1", key_down); end
        send_byte(8'h1C);
        checks++; if (key_down !== 1'b0) begin errors++; $display("FAIL a_break_down: got %b want 0", key_down); end
        checks++; if ({seg3, seg2, seg1, seg0} !== 32'hFFFF_FFFF) begin errors++; $display("FAIL a_break_blank: got %h want ffffffff", {seg3, seg2, seg1, seg0}); end
        checks++; if ({seg5, seg4} !== 16'hC0F9) begin errors++; $display("FAIL a_break_cnt_segs: got %h want c0f9", {seg5, seg4}); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] tm [7];
        int base;
        int bad;
        int n;
        tm = '{8'h1C, 8'h1C, 8'h1C, 8'h1C, 8'h1C, 8'hF0, 8'h1C};
        do_reset();
        base = pop_cyc.size();
        @(negedge clk);
        kb_bus.kb_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            kb_bus.kb_data = tm[i];
            #1;
            n = 0;
            while (kb_bus.kb_nextdata_n !== 1'b0 && n < 20) begin
                @(negedge clk);
                n++;
            end
            checks++;
            if (n >= 20) begin errors++; $display("FAIL b2b_timeout: byte %0d not popped", i); end
            @(posedge clk);
            #1;
        end
        kb_bus.kb_ready = 1'b0;
        repeat (4) @(negedge clk);
        checks++; if (pop_cyc.size() - base !== 7) begin errors++; $display("FAIL b2b_pop_count: got %0d want 7", pop_cyc.size() - base); end
        bad = 0;
        for (int i = base + 1; i < pop_cyc.size(); i++)
            if (pop_cyc[i] - pop_cyc[i-1] != 3) bad++;
        checks++; if (bad !== 0) begin errors++; $display("FAIL b2b_spacing: got %0d gaps not equal to 3 cycles want 0", bad); end
        checks++; if (key_cnt !== 8'h01) begin errors++; $display("FAIL b2b_typematic_cnt: got %h want 01", key_cnt); end
        checks++; if (key_down !== 1'b0) begin errors++; $display("FAIL b2b_released: got %b want 0", key_down); end
    endtask

    task automatic test_extended();
        do_reset();
        send_byte(8'hE0);
        checks++; if (key_down !== 1'b0 || key_cnt !== 8'h00) begin errors++; $display("FAIL ext_prefix_quiet: got down=%b cnt=%h want 0/00", key_down, key_cnt); end
        send_byte(8'h75);
        checks++; if (key_ext !== 1'b1 || key_down !== 1'b1) begin errors++; $display("FAIL ext_make_flags: got ext=%b down=%b want 1/1", key_ext, key_down); end
        checks++; if (scan_code !== 8'h75 || ascii !== 8'h00) begin errors++; $display("FAIL ext_make_codes: got %h/%h want 75/00", scan_code, ascii); end
        send_byte(8'hF0);
        send_byte(8'h75);
        checks++; if (key_down !== 1'b1) begin errors++; $display("FAIL ext_plain_break_ignored: got %b want 1", key_down); end
        send_byte(8'hE0);
        send_byte(8'hF0);
        send_byte(8'h75);
        checks++; if (key_down !== 1'b0) begin errors++; $display("FAIL ext_break: got %b want 0", key_down); end
        checks++; if (key_cnt !== 8'h01) begin errors++; $display("FAIL ext_cnt: got %h want 01", key_cnt); end
    endtask

    task automatic test_replace();
        do_reset();
        send_byte(8'h1C);
        send_byte(8'h32);
        checks++; if (scan_code !== 8'h32 || ascii !== 8'h62) begin errors++; $display("FAIL repl_codes: got %h/%h want 32/62", scan_code, ascii); end
        checks++; if (key_cnt !== 8'h02) begin errors++; $display("FAIL repl_cnt: got %h want 02", key_cnt); end
        send_byte(8'hF0);
        send_byte(8'h1C);
        checks++; if (key_down !== 1'b1) begin errors++; $display("FAIL repl_old_break_ignored: got %b want 1", key_down); end
    endtask

    task automatic test_wrap();
        logic [7:0] code;
        do_reset();
        for (int i = 0; i < 256; i++) begin
            code = (i % 2 == 1) ? 8'h1E : 8'h16;
            send_byte(code);
            if (i == 0) begin
                checks++; if (ascii !== 8'h31) begin errors++; $display("FAIL wrap_digit_ascii: got %h want 31", ascii); end
            end
            if (i == 254) begin
                checks++; if (key_cnt !== 8'hFF || {seg5, seg4} !== 16'h8E8E) begin errors++; $display("FAIL wrap_ff: got cnt=%h segs=%h want ff/8e8e", key_cnt, {seg5, seg4}); end
            end
            send_byte(8'hF0);
            send_byte(code);
        end
        checks++; if (key_cnt !== 8'h00) begin errors++; $display("FAIL wrap_cnt: got %h want 00", key_cnt); end
        checks++; if ({seg5, seg4} !== 16'hC0C0) begin errors++; $display("FAIL wrap_segs: got %h want c0c0", {seg5, seg4}); end
    endtask

    task automatic test_overflow();
        do_reset();
        @(negedge clk);
        kb_bus.kb_overflow = 1'b1;
        @(negedge clk);
        kb_bus.kb_overflow = 1'b0;
        checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b want 1", ovf); end
        repeat (5) @(negedge clk);
        checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b want 1", ovf); end
        send_byte(8'h45);
        checks++; if (ascii !== 8'h30 || key_down !== 1'b1) begin errors++; $display("FAIL ovf_decode: got ascii=%h down=%b want 30/1", ascii, key_down); end
        checks++; if ({seg3, seg2} !== 16'hB0C0) begin errors++; $display("FAIL ovf_ascii_segs: got %h want b0c0", {seg3, seg2}); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        send_byte(8'h1C);
        pop_byte(8'h32);
        #2;
        rst = 1'b1;
        #1;
        checks++; if (key_cnt !== 8'h00 || key_down !== 1'b0) begin errors++; $display("FAIL rstmid_state: got cnt=%h down=%b want 00/0", key_cnt, key_down); end
        checks++; if (seg0 !== 8'hFF || {seg5, seg4} !== 16'hC0C0) begin errors++; $display("FAIL rstmid_segs: got seg0=%h seg54=%h want ff/c0c0", seg0, {seg5, seg4}); end
        checks++; if (kb_bus.kb_nextdata_n !== 1'b1 || scan_code !== 8'h00) begin errors++; $display("FAIL rstmid_misc: got n=%b code=%h want 1/00", kb_bus.kb_nextdata_n, scan_code); end
        @(negedge clk);
        rst = 1'b0;
        send_byte(8'h1C);
        checks++; if (key_cnt !== 8'h01 || scan_code !== 8'h1C) begin errors++; $display("FAIL rstmid_recover: got cnt=%h code=%h want 01/1c", key_cnt, scan_code); end
    endtask

    initial begin
        kb_bus.kb_data     = 8'h00;
        kb_bus.kb_ready    = 1'b0;
        kb_bus.kb_overflow = 1'b0;
        test_reset();
        test_make_break();
        test_back_to_back();
        test_extended();
        test_replace();
        test_wrap();
        test_overflow();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
